// File: rtl/acc32_stream.sv
// Streaming 32-bit accumulator: sums a valid/ready operand stream through adder32
// and presents the per-frame total. Optional saturation: define ACC32_SATURATE_EN.

module adder32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum,
    output logic        carry_out
);
    assign {carry_out, sum} = {1'b0, a} + {1'b0, b};
endmodule

module acc32_stream #(
    parameter int MAX_LEN = 256,
    parameter int HI_W    = 8,
    localparam int CNT_W  = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_sum,
    output logic [HI_W-1:0]  out_hi,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t            state, state_nxt;
    logic [31:0]       acc_lo, acc_lo_nxt;
    logic [HI_W-1:0]   acc_hi, acc_hi_nxt;
    logic [CNT_W-1:0]  count, count_nxt;
    logic              ovf, ovf_nxt;
    logic [31:0]       add_sum;
    logic              add_carry;
    logic              accept, close, out_fire;

    adder32 u_adder (
        .a         (acc_lo),
        .b         (in_data),
        .sum       (add_sum),
        .carry_out (add_carry)
    );

    assign in_ready  = rst_n && (state != DONE);
    assign accept    = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign count_nxt = count + CNT_W'(1);
    assign close     = accept && (in_last || (count_nxt == CNT_W'(MAX_LEN)));

    always_comb begin
        acc_lo_nxt = add_sum;
        acc_hi_nxt = acc_hi;
        ovf_nxt    = ovf;
`ifdef ACC32_SATURATE_EN
        // Once saturated the low word is pinned for the remainder of the frame.
        if (ovf || add_carry) begin
            acc_lo_nxt = '1;
        end
        acc_hi_nxt = '0;
        ovf_nxt    = ovf | add_carry;
`else
        acc_hi_nxt = acc_hi + HI_W'(add_carry);
        ovf_nxt    = ovf | (add_carry && (&acc_hi));
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, ACCUM: begin
                if (accept) begin
                    state_nxt = close ? DONE : ACCUM;
                end
            end
            DONE: begin
                if (out_fire) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Accept and output handshake are mutually exclusive: in_ready is low in DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_lo    <= '0;
            acc_hi    <= '0;
            count     <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_hi    <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else if (accept) begin
            acc_lo <= acc_lo_nxt;
            acc_hi <= acc_hi_nxt;
            count  <= count_nxt;
            ovf    <= ovf_nxt;
            if (close) begin
                out_valid <= 1'b1;
                out_sum   <= acc_lo_nxt;
                out_hi    <= acc_hi_nxt;
                out_count <= count_nxt;
                out_ovf   <= ovf_nxt;
            end
        end else if (out_fire) begin
            out_valid <= 1'b0;
            acc_lo    <= '0;
            acc_hi    <= '0;
            count     <= '0;
            ovf       <= 1'b0;
        end
    end
endmodule

// File: tb/tb_acc32_stream.sv
// Directed bench for acc32_stream: default, MAX_LEN=4 and HI_W=2 instances
// checked with immediate assertions against hand-computed frame results.

module tb_acc32_stream;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    logic        in_valid [3];
    logic [31:0] in_data  [3];
    logic        in_last  [3];
    logic        out_ready[3];

    logic        rdy0, rdy1, rdy2;
    logic        vld0, vld1, vld2;
    logic [31:0] sum0, sum1, sum2;
    logic [7:0]  hi0, hi1;
    logic [1:0]  hi2;
    logic [8:0]  cnt0, cnt2;
    logic [2:0]  cnt1;
    logic        ovf0, ovf1, ovf2;

    always #5 clk = ~clk;

    acc32_stream u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(rdy0), .in_data(in_data[0]), .in_last(in_last[0]),
        .out_valid(vld0), .out_ready(out_ready[0]),
        .out_sum(sum0), .out_hi(hi0), .out_count(cnt0), .out_ovf(ovf0)
    );

    acc32_stream #(.MAX_LEN(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(rdy1), .in_data(in_data[1]), .in_last(in_last[1]),
        .out_valid(vld1), .out_ready(out_ready[1]),
        .out_sum(sum1), .out_hi(hi1), .out_count(cnt1), .out_ovf(ovf1)
    );

    acc32_stream #(.HI_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[2]), .in_ready(rdy2), .in_data(in_data[2]), .in_last(in_last[2]),
        .out_valid(vld2), .out_ready(out_ready[2]),
        .out_sum(sum2), .out_hi(hi2), .out_count(cnt2), .out_ovf(ovf2)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic getOut(input int u, output logic v, output logic r, output logic [31:0] s,
                          output logic [7:0] h, output logic [8:0] c, output logic o);
        case (u)
            0: begin v = vld0; r = rdy0; s = sum0; h = hi0; c = cnt0; o = ovf0; end
            1: begin v = vld1; r = rdy1; s = sum1; h = hi1; c = {6'd0, cnt1}; o = ovf1; end
            default: begin v = vld2; r = rdy2; s = sum2; h = {6'd0, hi2}; c = cnt2; o = ovf2; end
        endcase
    endtask

    // Drive one beat just after a negedge; returns at the following negedge.
    task automatic applyStimulus(input int u, input logic [31:0] d, input logic last);
        in_valid[u] = 1'b1;
        in_data[u]  = d;
        in_last[u]  = last;
        @(posedge clk);
        @(negedge clk);
        in_valid[u] = 1'b0;
        in_last[u]  = 1'b0;
    endtask

    task automatic checkOutput(input int u, input string tag, input logic [31:0] esum,
                               input logic [7:0] ehi, input logic [8:0] ecnt, input logic eovf);
        logic v, r, o;
        logic [31:0] s;
        logic [7:0] h;
        logic [8:0] c;
        getOut(u, v, r, s, h, c, o);
        check({tag, ".valid"}, 64'(v), 64'(1));
        check({tag, ".ready"}, 64'(r), 64'(0));
        check({tag, ".sum"},   64'(s), 64'(esum));
        check({tag, ".hi"},    64'(h), 64'(ehi));
        check({tag, ".count"}, 64'(c), 64'(ecnt));
        check({tag, ".ovf"},   64'(o), 64'(eovf));
    endtask

    task automatic handshake(input int u, input string tag);
        logic v, r, o;
        logic [31:0] s;
        logic [7:0] h;
        logic [8:0] c;
        out_ready[u] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready[u] = 1'b0;
        getOut(u, v, r, s, h, c, o);
        check({tag, ".hs_valid"}, 64'(v), 64'(0));
        check({tag, ".hs_ready"}, 64'(r), 64'(1));
    endtask

    initial begin
        logic v, r, o;
        logic [31:0] s, held_sum;
        logic [7:0] h;
        logic [8:0] c;
        for (int i = 0; i < 3; i++) begin
            in_valid[i] = 1'b0;
            in_data[i] = '0;
            in_last[i] = 1'b0;
            out_ready[i] = 1'b0;
        end

        // Reset held with a pending operand on unit 0.
        rst_n = 1'b0;
        in_valid[0] = 1'b1;
        in_data[0] = 32'd5;
        repeat (3) @(posedge clk);
        @(negedge clk);
        getOut(0, v, r, s, h, c, o);
        check("rst.ready", 64'(r), 64'(0));
        check("rst.valid", 64'(v), 64'(0));
        check("rst.sum", 64'(s), 64'(0));
        check("rst.count", 64'(c), 64'(0));
        rst_n = 1'b1;
        in_valid[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        getOut(0, v, r, s, h, c, o);
        check("post_rst.ready", 64'(r), 64'(1));
        check("post_rst.valid", 64'(v), 64'(0));
        applyStimulus(0, 32'd7, 1'b1);
        checkOutput(0, "f7", 32'd7, 8'd0, 9'd1, 1'b0);
        handshake(0, "f7");

        applyStimulus(0, 32'h1234_5678, 1'b1);
        checkOutput(0, "single", 32'h1234_5678, 8'd0, 9'd1, 1'b0);
        handshake(0, "single");
        getOut(0, v, r, s, h, c, o);
        check("single.kept_sum", 64'(s), 64'(32'h1234_5678));

        applyStimulus(0, 32'h8000_0000, 1'b0);
        applyStimulus(0, 32'h8000_0000, 1'b0);
        getOut(0, v, r, s, h, c, o);
        check("carry.midvalid", 64'(v), 64'(0));
        applyStimulus(0, 32'h7FFF_FFFF, 1'b1);
`ifdef ACC32_SATURATE_EN
        checkOutput(0, "carry", 32'hFFFF_FFFF, 8'd0, 9'd3, 1'b1);
`else
        checkOutput(0, "carry", 32'h7FFF_FFFF, 8'd1, 9'd3, 1'b0);
`endif
        held_sum = sum0;

        // Backpressure: pending result blocks further operands, even with in_last.
        in_valid[0] = 1'b1;
        in_data[0] = 32'h55;
        in_last[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            getOut(0, v, r, s, h, c, o);
            check("bp.ready", 64'(r), 64'(0));
            check("bp.valid", 64'(v), 64'(1));
            check("bp.sum", 64'(s), 64'(held_sum));
        end
        in_valid[0] = 1'b0;
        in_last[0] = 1'b0;
        handshake(0, "bp");
        applyStimulus(0, 32'h1, 1'b1);
        checkOutput(0, "after_bp", 32'h1, 8'd0, 9'd1, 1'b0);
        handshake(0, "after_bp");

        // MAX_LEN=4 closes on the fourth beat without in_last.
        for (int k = 0; k < 3; k++) applyStimulus(1, 32'hFFFF_FFFF, 1'b0);
        getOut(1, v, r, s, h, c, o);
        check("maxlen.early_valid", 64'(v), 64'(0));
        check("maxlen.early_ready", 64'(r), 64'(1));
        applyStimulus(1, 32'hFFFF_FFFF, 1'b0);
`ifdef ACC32_SATURATE_EN
        checkOutput(1, "maxlen", 32'hFFFF_FFFF, 8'd0, 9'd4, 1'b1);
`else
        checkOutput(1, "maxlen", 32'hFFFF_FFFC, 8'd3, 9'd4, 1'b0);
`endif
        handshake(1, "maxlen");

        // HI_W=2: four carries wrap the high word to 0 and flag overflow.
        for (int k = 0; k < 4; k++) applyStimulus(2, 32'hFFFF_FFFF, 1'b0);
        applyStimulus(2, 32'hFFFF_FFFF, 1'b1);
`ifdef ACC32_SATURATE_EN
        checkOutput(2, "wrap", 32'hFFFF_FFFF, 8'd0, 9'd5, 1'b1);
`else
        checkOutput(2, "wrap", 32'hFFFF_FFFB, 8'd0, 9'd5, 1'b1);
`endif
        handshake(2, "wrap");

        // Mid-frame reset discards the partial frame.
        applyStimulus(2, 32'h100, 1'b0);
        applyStimulus(2, 32'h200, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        getOut(2, v, r, s, h, c, o);
        check("midrst.valid", 64'(v), 64'(0));
        applyStimulus(2, 32'd9, 1'b1);
        checkOutput(2, "midrst", 32'd9, 8'd0, 9'd1, 1'b0);
        handshake(2, "midrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] timeout");
    end
endmodule
